// File: rtl/mx_pkg.sv
// mx_pkg: shared types and default parameters for the MX shared-exponent block
// Contents: state_t (FILL/DRAIN) and default width/size constants.
package mx_pkg;
    typedef enum logic {FILL, DRAIN} state_t;
    localparam int default_width_i = 9;
    localparam int default_width_e = 8;
    localparam int default_block_size = 32;
endpackage

// File: rtl/mx_shared_exp.sv
// mx_shared_exp: buffers one MX block, finds its max exponent and replays elements with per-element right-shift
// Ports: i_clk, i_rst_n (sync active-low); input stream i_num/i_exp/i_valid/o_ready;
//        output stream o_num/o_shift/o_scale/o_last/o_valid/i_ready.
// Option: MX_ZERO_SKIP_EN makes zero mantissas ignored by the running max.
module mx_shared_exp
    import mx_pkg::*;
#(
    parameter int width_i = default_width_i,
    parameter int width_e = default_width_e,
    parameter int block_size = default_block_size,
    parameter int width_shift = $clog2(width_i + 2)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic signed [width_i-1:0] i_num,
    input  logic [width_e-1:0]        i_exp,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic signed [width_i-1:0] o_num,
    output logic [width_shift-1:0]    o_shift,
    output logic [width_e-1:0]        o_scale,
    output logic                      o_last,
    output logic                      o_valid,
    input  logic                      i_ready
);
    localparam int cw = $clog2(block_size);
    localparam logic [cw-1:0] last_idx = cw'(block_size - 1);
    localparam logic [width_e:0] sat = (width_e + 1)'(width_i);

    state_t state;
    logic [cw-1:0] wr_cnt, rd_cnt;
    logic [width_e-1:0] max_exp;
    logic signed [width_i-1:0] num_buf [block_size];
    logic [width_e-1:0] exp_buf [block_size];
    logic upd;
    logic [width_e:0] diff;

`ifdef MX_ZERO_SKIP_EN
    assign upd = i_num != '0;
`else
    assign upd = 1'b1;
`endif

    // A negative difference only occurs for skipped zero elements; it clamps to 0.
    assign diff = {1'b0, max_exp} - {1'b0, exp_buf[rd_cnt]};
    assign o_shift = diff[width_e] ? '0 : (diff > sat ? width_shift'(width_i) : diff[width_shift-1:0]);
    assign o_num = num_buf[rd_cnt];
    assign o_scale = max_exp;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= FILL;
            wr_cnt <= '0;
            rd_cnt <= '0;
            max_exp <= '0;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_last <= 1'b0;
        end else if (state == FILL) begin
            if (i_valid) begin
                num_buf[wr_cnt] <= i_num;
                exp_buf[wr_cnt] <= i_exp;
                if (upd && i_exp > max_exp) max_exp <= i_exp;
                if (wr_cnt == last_idx) begin
                    wr_cnt <= '0;
                    state <= DRAIN;
                    o_valid <= 1'b1;
                    o_ready <= 1'b0;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end else if (i_ready) begin
            if (rd_cnt == last_idx) begin
                rd_cnt <= '0;
                state <= FILL;
                max_exp <= '0;
                o_valid <= 1'b0;
                o_ready <= 1'b1;
                o_last <= 1'b0;
            end else begin
                rd_cnt <= rd_cnt + 1'b1;
                o_last <= rd_cnt == last_idx - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mx_shared_exp.sv
// tb_mx_shared_exp: directed self-checking bench for mx_shared_exp with block_size=4
module tb_mx_shared_exp;
    typedef logic signed [8:0] num4_t [4];
    typedef logic [7:0] exp4_t [4];
    typedef logic [3:0] sh4_t [4];

    logic i_clk = 0, i_rst_n = 0, i_valid = 0, i_ready = 0;
    logic signed [8:0] i_num = '0;
    logic [7:0] i_exp = '0;
    logic o_ready, o_last, o_valid;
    logic signed [8:0] o_num;
    logic [3:0] o_shift;
    logic [7:0] o_scale;
    int tests = 0, fails = 0;

    mx_shared_exp #(.width_i(9), .width_e(8), .block_size(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_num(i_num), .i_exp(i_exp), .i_valid(i_valid),
        .o_ready(o_ready), .o_num(o_num), .o_shift(o_shift), .o_scale(o_scale),
        .o_last(o_last), .o_valid(o_valid), .i_ready(i_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic feed(num4_t n, exp4_t e);
        for (int i = 0; i < 4; i++) begin
            check("fill_ready", 32'(o_ready), 1);
            i_valid = 1;
            i_num = n[i];
            i_exp = e[i];
            @(negedge i_clk);
        end
    endtask

    task automatic drain(string tag, num4_t n, sh4_t s, logic [7:0] scale, logic [5:0] pat,
                         logic nv, logic signed [8:0] nn, logic [7:0] ne);
        int idx = 0, cyc = 0;
        i_valid = nv;
        i_num = nn;
        i_exp = ne;
        check({tag, "_latency"}, 32'(o_valid), 1);
        check({tag, "_busy"}, 32'(o_ready), 0);
        while (idx < 4 && cyc < 16) begin
            i_ready = pat[cyc % 6];
            check({tag, "_valid"}, 32'(o_valid), 1);
            check({tag, "_num"}, 32'(o_num), 32'(n[idx]));
            check({tag, "_shift"}, 32'(o_shift), 32'(s[idx]));
            check({tag, "_scale"}, 32'(o_scale), 32'(scale));
            check({tag, "_last"}, 32'(o_last), 32'(idx == 3));
            @(negedge i_clk);
            if (i_ready) idx++;
            cyc++;
        end
        check({tag, "_handshakes"}, 32'(idx), 4);
        i_ready = 0;
        check({tag, "_done_ready"}, 32'(o_ready), 1);
        check({tag, "_done_valid"}, 32'(o_valid), 0);
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        check("rst_ready", 32'(o_ready), 1);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_last", 32'(o_last), 0);
        i_rst_n = 1;
        @(negedge i_clk);

        feed('{9'sd5, -9'sd3, 9'sd100, -9'sd256}, '{8'd10, 8'd12, 8'd7, 8'd12});
        drain("basic", '{9'sd5, -9'sd3, 9'sd100, -9'sd256}, '{4'd2, 4'd0, 4'd5, 4'd0}, 8'd12,
              6'b111111, 0, 0, 0);

        feed('{9'sd1, 9'sd2, 9'sd3, 9'sd4}, '{8'd0, 8'd200, 8'd3, 8'd4});
        drain("sat_stall", '{9'sd1, 9'sd2, 9'sd3, 9'sd4}, '{4'd9, 4'd0, 4'd9, 4'd9}, 8'd200,
              6'b111001, 0, 0, 0);

        feed('{9'sd11, 9'sd12, 9'sd13, 9'sd14}, '{8'd50, 8'd40, 8'd30, 8'd20});
        drain("b2b_a", '{9'sd11, 9'sd12, 9'sd13, 9'sd14}, '{4'd0, 4'd9, 4'd9, 4'd9}, 8'd50,
              6'b111111, 1, -9'sd21, 8'd1);
        feed('{-9'sd21, 9'sd22, -9'sd23, 9'sd24}, '{8'd1, 8'd3, 8'd2, 8'd0});
        drain("b2b_b", '{-9'sd21, 9'sd22, -9'sd23, 9'sd24}, '{4'd2, 4'd0, 4'd1, 4'd3}, 8'd3,
              6'b111111, 0, 0, 0);

        for (int i = 0; i < 2; i++) begin
            i_valid = 1;
            i_num = 9'(70 + i);
            i_exp = 8'(100 - i);
            @(negedge i_clk);
        end
        i_valid = 0;
        i_rst_n = 0;
        @(negedge i_clk);
        i_rst_n = 1;
        check("midrst_ready", 32'(o_ready), 1);
        check("midrst_valid", 32'(o_valid), 0);
        feed('{9'sd31, 9'sd32, 9'sd33, 9'sd34}, '{8'd10, 8'd12, 8'd7, 8'd12});
        drain("midrst", '{9'sd31, 9'sd32, 9'sd33, 9'sd34}, '{4'd2, 4'd0, 4'd5, 4'd0}, 8'd12,
              6'b111111, 0, 0, 0);

        feed('{9'sd0, 9'sd7, 9'sd0, 9'sd1}, '{8'd30, 8'd5, 8'd20, 8'd4});
`ifdef MX_ZERO_SKIP_EN
        drain("zskip", '{9'sd0, 9'sd7, 9'sd0, 9'sd1}, '{4'd0, 4'd0, 4'd0, 4'd1}, 8'd5,
              6'b111111, 0, 0, 0);
`else
        drain("zskip", '{9'sd0, 9'sd7, 9'sd0, 9'sd1}, '{4'd0, 4'd9, 4'd9, 4'd9}, 8'd30,
              6'b111111, 0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
